calc_engine: RTL and testbench
==============================

CALC_ENGINE -- requirements
Module: calc_engine

Interface
REQ-001 Parameter W, default 4, operand/result width in bits (legal W >= 2).
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; accepted only when busy=0.
REQ-005 abort  input  1  synchronous cancel of an operation in progress.
REQ-006 OP_in  input  3  operation code, sampled at accept.
REQ-007 X  input  W  first operand, sampled at accept.
REQ-008 Y  input  W  second operand, sampled at accept.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 errFlag  output  1  divide-by-zero indicator.
REQ-012 OP_out  output  3  opcode of the last accepted operation.
REQ-013 Hi  output  W  upper result word.
REQ-014 Lo  output  W  lower result word.

Function
REQ-015 Opcodes SHALL be: 000 PASSX, 001 PASSY, 010 ADD, 011 SUB, 100 MUL, 101 DIV, 110 AND, 111 XOR.
REQ-016 Accept SHALL occur on an edge with start=1 and state IDLE; X, Y and OP_in are latched internally and OP_out is updated.
REQ-017 States SHALL be: IDLE, ALU, RUN, ERR; busy=1 in every state except IDLE.
REQ-018 Accept of opcodes 000-011 or 110-111 SHALL go IDLE->ALU; the next edge writes Hi/Lo, pulses done, and returns to IDLE (latency 1 edge).
REQ-019 PASSX/PASSY: Lo=operand, Hi=0; AND/XOR: Lo=bitwise result, Hi=0.
REQ-020 ADD SHALL give Lo=(X+Y) mod 2^W and Hi={0...,carry}.
REQ-021 SUB SHALL give Lo=(X-Y) mod 2^W and Hi={0...,borrow}, with borrow=1 iff X<Y (unsigned).
REQ-022 Accept of MUL, or of DIV with Y!=0, SHALL go IDLE->RUN with iteration counter=0; one iteration per edge; on the edge with counter=W-1 the block writes Hi/Lo, pulses done and returns to IDLE (latency W edges).
REQ-023 MUL SHALL be unsigned shift-add; {Hi,Lo}=X*Y (2W bits).
REQ-024 DIV SHALL be unsigned restoring division; Lo=quotient, Hi=remainder.
REQ-025 Accept of DIV with Y=0 SHALL go IDLE->ERR; the next edge sets errFlag=1, pulses done, leaves Hi/Lo unchanged and returns to IDLE.
REQ-026 errFlag SHALL hold until the next accept, which clears it to 0.
REQ-027 start while busy=1 SHALL be ignored; no queuing.
REQ-028 abort=1 in ALU/RUN/ERR SHALL return to IDLE on that edge, with no done pulse, Hi/Lo/errFlag unchanged; abort in IDLE SHALL have no effect.
REQ-029 Simultaneous abort and start in IDLE SHALL accept the start.
REQ-030 Hi and Lo SHALL change only on a completion edge.
REQ-031 The block SHALL allow back-to-back operation: start may be asserted in the cycle done=1, since state is IDLE.

Reset
REQ-032 rst=0 SHALL immediately force state=IDLE, counter=0, busy=0, done=0, errFlag=0, OP_out=0, Hi=0, Lo=0, and clear internal operand registers.
REQ-033 Reset mid-operation SHALL discard the operation with no done pulse.
REQ-034 Deassertion of rst SHALL take effect at the first clk edge after rst goes high; no accept occurs while rst=0.

Structure
REQ-035 Package calc_pkg SHALL hold the opcode constants and the state encoding; W stays a module parameter.
REQ-036 Iterative MUL/DIV SHALL live in one sub-module, seq_muldiv (load, mode, step, done-by-count, 2W result), shared by both operations.
REQ-037 ADD/SUB/logic SHALL be combinational inside calc_engine and registered at the ALU-state edge.

Verification (W=4)
REQ-038 ADD X=9, Y=8 -> done 1 edge after accept; Lo=1, Hi=1.
REQ-039 SUB X=3, Y=5 -> Lo=E, Hi=1; then SUB X=5, Y=3 back-to-back -> Lo=2, Hi=0.
REQ-040 MUL X=13, Y=11 -> busy for 4 edges, done on the 4th; Hi=8, Lo=F. DIV X=13, Y=4 -> Lo=3, Hi=1.
REQ-041 DIV X=7, Y=0 after a prior result Hi=8, Lo=F -> done with errFlag=1; Hi=8, Lo=F retained; next ADD clears errFlag.
REQ-042 MUL started with abort=1 at iteration 2 -> busy=0 next cycle, no done, Hi/Lo unchanged; start during RUN ignored.
REQ-043 rst=0 asserted mid-DIV -> all outputs 0 immediately; after release, ADD 1+1 -> Lo=2.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calc_engine block.
// Holds the opcode encoding and the controller state encoding. Operand width W stays a
// parameter of the modules that use it.
package calc_pkg;

    typedef enum logic [2:0] {
        OpPassX = 3'b000,
        OpPassY = 3'b001,
        OpAdd   = 3'b010,
        OpSub   = 3'b011,
        OpMul   = 3'b100,
        OpDiv   = 3'b101,
        OpAnd   = 3'b110,
        OpXor   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StAlu  = 2'b01,
        StRun  = 2'b10,
        StErr  = 2'b11
    } state_e;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiplier / restoring divider, one iteration per step.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   load         capture operands and clear the iteration counter
//   mode         0 = multiply a*b, 1 = divide a/b (sampled on load)
//   a, b         operands (sampled on load)
//   step         advance one iteration
//   last         counter is on its final iteration (W-1)
//   result       {hi, lo} after applying the current iteration; valid as the final
//                answer when last=1 (mul: product, div: {remainder, quotient})
module seq_muldiv #(
    parameter int unsigned W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           mode,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           step,
    output logic           last,
    output logic [2*W-1:0] result
);

    localparam int unsigned CntW = $clog2(W);
    localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

    logic            mode_q;
    logic [W-1:0]    m_q;    // multiplicand or divisor
    logic [W-1:0]    hi_q;   // partial product high half or partial remainder
    logic [W-1:0]    lo_q;   // multiplier being shifted out or quotient being shifted in
    logic [CntW-1:0] cnt_q;

    logic [W:0]      mul_sum;
    logic [W:0]      div_trial;
    logic [W:0]      div_diff;
    logic            div_ge;
    logic [W-1:0]    hi_d;
    logic [W-1:0]    lo_d;

    always_comb begin
        // Shift-add: conditionally add multiplicand to high half, then shift the
        // whole {carry, hi, lo} right by one.
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        // Restoring: shift next dividend bit into the remainder and try a subtract.
        div_trial = {hi_q, lo_q[W-1]};
        div_diff  = div_trial - {1'b0, m_q};
        div_ge    = (div_trial >= {1'b0, m_q});
        if (mode_q) begin
            hi_d = div_ge ? div_diff[W-1:0] : div_trial[W-1:0];
            lo_d = {lo_q[W-2:0], div_ge};
        end else begin
            hi_d = mul_sum[W:1];
            lo_d = {mul_sum[0], lo_q[W-1:1]};
        end
    end

    assign last   = (cnt_q == CntLast);
    assign result = {hi_d, lo_d};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= 1'b0;
            m_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            mode_q <= mode;
            m_q    <= mode ? b : a;
            hi_q   <= '0;
            lo_q   <= mode ? a : b;
            cnt_q  <= '0;
        end else if (step) begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            cnt_q  <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/calc_engine.sv
// Small arithmetic engine: single-cycle pass/add/sub/logic ops, iterative mul/div.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   start          request, accepted only when idle
//   abort          cancel an operation in progress (ignored when idle)
//   OP_in, X, Y    opcode and operands, sampled at accept
//   busy           high while an operation is in progress
//   done           one-cycle completion pulse
//   errFlag        divide-by-zero indicator, held until the next accept
//   OP_out         opcode of the last accepted operation
//   Hi, Lo         result words, updated only on completion
module calc_engine
    import calc_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [2:0]   OP_in,
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    output logic         busy,
    output logic         done,
    output logic         errFlag,
    output logic [2:0]   OP_out,
    output logic [W-1:0] Hi,
    output logic [W-1:0] Lo
);

    state_e       state;
    op_e          op_q;
    logic [W-1:0] x_q;
    logic [W-1:0] y_q;

    logic         in_div;
    logic         in_iter;
    logic         md_load;
    logic         md_step;
    logic         md_last;
    logic [2*W-1:0] md_result;

    logic [W:0]   alu_sum;
    logic [W:0]   alu_diff;
    logic [W-1:0] alu_hi;
    logic [W-1:0] alu_lo;

    // Divide by zero bypasses the iterative unit and goes straight to the error state.
    assign in_div  = (OP_in == OpDiv);
    assign in_iter = (OP_in == OpMul) || (in_div && (Y != '0));
    assign md_load = (state == StIdle) && start && in_iter;
    assign md_step = (state == StRun) && !abort;

    seq_muldiv #(
        .W(W)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .load   (md_load),
        .mode   (in_div),
        .a      (X),
        .b      (Y),
        .step   (md_step),
        .last   (md_last),
        .result (md_result)
    );

    always_comb begin
        alu_sum  = {1'b0, x_q} + {1'b0, y_q};
        alu_diff = {1'b0, x_q} - {1'b0, y_q};
        alu_hi   = '0;
        alu_lo   = '0;
        unique case (op_q)
            OpPassX: alu_lo = x_q;
            OpPassY: alu_lo = y_q;
            OpAdd: begin
                alu_lo    = alu_sum[W-1:0];
                alu_hi[0] = alu_sum[W];
            end
            OpSub: begin
                // Top bit of the widened difference is the borrow (X < Y).
                alu_lo    = alu_diff[W-1:0];
                alu_hi[0] = alu_diff[W];
            end
            OpAnd:   alu_lo = x_q & y_q;
            OpXor:   alu_lo = x_q ^ y_q;
            default: alu_lo = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= StIdle;
            op_q    <= OpPassX;
            x_q     <= '0;
            y_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            errFlag <= 1'b0;
            OP_out  <= 3'b000;
            Hi      <= '0;
            Lo      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    // Start wins over a simultaneous abort here.
                    if (start) begin
                        op_q    <= op_e'(OP_in);
                        x_q     <= X;
                        y_q     <= Y;
                        OP_out  <= OP_in;
                        errFlag <= 1'b0;
                        busy    <= 1'b1;
                        if (in_iter) begin
                            state <= StRun;
                        end else if (in_div) begin
                            state <= StErr;
                        end else begin
                            state <= StAlu;
                        end
                    end
                end
                StAlu: begin
                    if (!abort) begin
                        Hi   <= alu_hi;
                        Lo   <= alu_lo;
                        done <= 1'b1;
                    end
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                StRun: begin
                    if (abort) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (md_last) begin
                        Hi    <= md_result[2*W-1:W];
                        Lo    <= md_result[W-1:0];
                        done  <= 1'b1;
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                StErr: begin
                    if (!abort) begin
                        errFlag <= 1'b1;
                        done    <= 1'b1;
                    end
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_engine.sv
// Scoreboard bench for calc_engine (W=4): directed operations push expected results,
// a negedge monitor pops and compares whenever done is seen.
module tb_calc_engine;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [2:0]   OP_in;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         busy;
    logic         done;
    logic         errFlag;
    logic [2:0]   OP_out;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;

    always #5 clk = ~clk;

    calc_engine #(
        .W(W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .OP_in   (OP_in),
        .X       (X),
        .Y       (Y),
        .busy    (busy),
        .done    (done),
        .errFlag (errFlag),
        .OP_out  (OP_out),
        .Hi      (Hi),
        .Lo      (Lo)
    );

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] hi;
        logic [3:0] lo;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t mk(input logic [2:0] op, input logic [3:0] hi,
                                input logic [3:0] lo, input logic err);
        exp_t e;
        e.op  = op;
        e.hi  = hi;
        e.lo  = lo;
        e.err = err;
        return e;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 (Hi=%h Lo=%h)", Hi, Lo);
            end else begin
                e = sb.pop_front();
                chk("done_op_out", {5'd0, OP_out}, {5'd0, e.op});
                chk("done_hi", {4'd0, Hi}, {4'd0, e.hi});
                chk("done_lo", {4'd0, Lo}, {4'd0, e.lo});
                chk("done_err", {7'd0, errFlag}, {7'd0, e.err});
            end
        end
    end

    // Call at a negedge; holds the request across one rising edge.
    task automatic issue(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y,
                         input logic push, input exp_t e);
        start = 1'b1;
        OP_in = op;
        X     = x;
        Y     = y;
        if (push) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge where done is seen; n = edges since the accept edge.
    task automatic wait_done(input string name, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) return;
        end
        checks++;
        failures++;
        $display("FAIL %s_timeout actual=no_done required=done", name);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"}, {7'd0, busy}, 8'd0);
        chk({name, "_done"}, {7'd0, done}, 8'd0);
        chk({name, "_err"}, {7'd0, errFlag}, 8'd0);
        chk({name, "_op_out"}, {5'd0, OP_out}, 8'd0);
        chk({name, "_hi"}, {4'd0, Hi}, 8'd0);
        chk({name, "_lo"}, {4'd0, Lo}, 8'd0);
    endtask

    initial begin
        int   n;
        exp_t none;
        none  = '0;
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        OP_in = 3'b000;
        X     = '0;
        Y     = '0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // ADD with carry out
        issue(3'b010, 4'd9, 4'd8, 1'b1, mk(3'b010, 4'h1, 4'h1, 1'b0));
        wait_done("add", n);
        chk("add_latency", 8'(n), 8'd1);

        // SUB with borrow, then back-to-back SUB in the done cycle
        issue(3'b011, 4'd3, 4'd5, 1'b1, mk(3'b011, 4'h1, 4'hE, 1'b0));
        wait_done("sub1", n);
        chk("sub1_latency", 8'(n), 8'd1);
        issue(3'b011, 4'd5, 4'd3, 1'b1, mk(3'b011, 4'h0, 4'h2, 1'b0));
        wait_done("sub2", n);
        chk("sub2_latency", 8'(n), 8'd1);

        // MUL 13*11 = 143 = 0x8F
        issue(3'b100, 4'd13, 4'd11, 1'b1, mk(3'b100, 4'h8, 4'hF, 1'b0));
        chk("mul_busy", {7'd0, busy}, 8'd1);
        wait_done("mul", n);
        chk("mul_latency", 8'(n), 8'd4);

        // DIV 13/4 = 3 r 1
        issue(3'b101, 4'd13, 4'd4, 1'b1, mk(3'b101, 4'h1, 4'h3, 1'b0));
        wait_done("div", n);
        chk("div_latency", 8'(n), 8'd4);

        // Divide by zero keeps the previous MUL result
        issue(3'b100, 4'd13, 4'd11, 1'b1, mk(3'b100, 4'h8, 4'hF, 1'b0));
        wait_done("mul2", n);
        issue(3'b101, 4'd7, 4'd0, 1'b1, mk(3'b101, 4'h8, 4'hF, 1'b1));
        wait_done("div0", n);
        chk("div0_latency", 8'(n), 8'd1);
        @(negedge clk);
        chk("err_held", {7'd0, errFlag}, 8'd1);

        // ADD with simultaneous abort is accepted and clears errFlag
        abort = 1'b1;
        issue(3'b010, 4'd2, 4'd3, 1'b1, mk(3'b010, 4'h0, 4'h5, 1'b0));
        abort = 1'b0;
        wait_done("add_abort_idle", n);

        // Pass and logic ops
        issue(3'b000, 4'h6, 4'h9, 1'b1, mk(3'b000, 4'h0, 4'h6, 1'b0));
        wait_done("passx", n);
        issue(3'b001, 4'h6, 4'h9, 1'b1, mk(3'b001, 4'h0, 4'h9, 1'b0));
        wait_done("passy", n);
        issue(3'b110, 4'hC, 4'hA, 1'b1, mk(3'b110, 4'h0, 4'h8, 1'b0));
        wait_done("and", n);
        issue(3'b111, 4'hC, 4'hA, 1'b1, mk(3'b111, 4'h0, 4'h6, 1'b0));
        wait_done("xor", n);

        // MUL aborted at iteration 2; a start during RUN is ignored
        @(negedge clk);
        issue(3'b100, 4'd13, 4'd11, 1'b0, none);
        start = 1'b1;
        OP_in = 3'b010;
        X     = 4'd1;
        Y     = 4'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", {7'd0, busy}, 8'd0);
        chk("abort_done", {7'd0, done}, 8'd0);
        chk("abort_hi", {4'd0, Hi}, 8'h00);
        chk("abort_lo", {4'd0, Lo}, 8'h06);
        chk("abort_op_out", {5'd0, OP_out}, 8'd4);
        repeat (6) @(negedge clk);

        // Reset in the middle of a DIV
        issue(3'b101, 4'd13, 4'd4, 1'b0, none);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(3'b010, 4'd1, 4'd1, 1'b1, mk(3'b010, 4'h0, 4'h2, 1'b0));
        wait_done("add_after_rst", n);
        chk("add_after_rst_latency", 8'(n), 8'd1);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 8'(sb.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
